// File: rtl/vram_plane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vram_plane_ctrl
// Brief    : Banked VRAM of PLANES bit-planes (2**AW x DW each). It has one CPU
//            port (reads one selected plane, writes broadcast under a mask) and
//            one independent video fetch port. The optional hardware clear
//            sequencer is built only when VRAM_CLR_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module vram_plane_ctrl #(
    parameter int PLANES = 6,
    parameter int AW     = 13,
    parameter int DW     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_ce_n,
    input  logic                 cpu_wr_n,
    input  logic [AW-1:0]        cpu_addr,
    input  logic [DW-1:0]        cpu_din,
    output logic [DW-1:0]        cpu_dout,
    input  logic [7:0]           rd_bank,
    input  logic [PLANES-1:0]    wr_mask,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 clr_done,
    input  logic [AW-1:0]        vaddr,
    output logic [PLANES*DW-1:0] vdata
);
    localparam int c_depth = 1 << AW;

    logic                      w_clr_active;
    logic                      w_clr_we;
    logic [AW-1:0]             w_clr_addr;
    logic                      w_cpu_rd;
    logic                      w_cpu_wr;
    logic [PLANES-1:0]         w_we;
    logic [AW-1:0]             w_waddr;
    logic [DW-1:0]             w_wdata;
    logic [PLANES-1:0][DW-1:0] w_plane_rd;
    logic [DW-1:0]             w_rd_sel;

`ifdef VRAM_CLR_EN
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_clear = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]    r_state;
    logic [AW-1:0] r_clr_cnt;

    // The counter wraps to zero on the last write, so IDLE always restarts at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (clr_start) begin
                        r_state   <= c_st_clear;
                        r_clr_cnt <= '0;
                    end
                end
                c_st_clear: begin
                    r_clr_cnt <= r_clr_cnt + AW'(1);
                    if (r_clr_cnt == {AW{1'b1}}) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign w_clr_active = (r_state == c_st_clear);
    assign w_clr_addr   = r_clr_cnt;
    assign clr_busy     = w_clr_active;
    assign clr_done     = (r_state == c_st_done);
`else
    logic w_unused_clr_start;
    assign w_unused_clr_start = clr_start;
    assign w_clr_active       = 1'b0;
    assign w_clr_addr         = '0;
    assign clr_busy           = 1'b0;
    assign clr_done           = 1'b0;
`endif

    // A reset edge suppresses the pending clear write, leaving planes partially cleared.
    assign w_clr_we = w_clr_active & ~reset;
    assign w_cpu_rd = ~cpu_ce_n & cpu_wr_n;
    assign w_cpu_wr = ~cpu_ce_n & ~cpu_wr_n & ~w_clr_active;
    assign w_we     = w_clr_we ? {PLANES{1'b1}} : (w_cpu_wr ? wr_mask : '0);
    assign w_waddr  = w_clr_active ? w_clr_addr : cpu_addr;
    assign w_wdata  = w_clr_active ? '0 : cpu_din;

    generate
        for (genvar gi = 0; gi < PLANES; gi++) begin : g_plane
            logic [DW-1:0] r_mem [c_depth];
            logic [DW-1:0] r_vq;

            always_ff @(posedge clk) begin
                if (w_we[gi]) begin
                    r_mem[w_waddr] <= w_wdata;
                end
            end

            // The non-blocking update yields old data on a same-address write.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vq <= '0;
                end else begin
                    r_vq <= r_mem[vaddr];
                end
            end

            assign w_plane_rd[gi]        = r_mem[cpu_addr];
            assign vdata[gi*DW +: DW]    = r_vq;
        end
    endgenerate

    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < PLANES; i++) begin
            if (rd_bank == 8'(i + 1)) begin
                w_rd_sel = w_plane_rd[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_dout <= '0;
        end else if (w_cpu_rd) begin
            cpu_dout <= w_clr_active ? '0 : w_rd_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_plane_ctrl.sv
`default_nettype none
// Testbench for vram_plane_ctrl: directed vectors, a behavioural VRAM model
// compared every cycle, and literal expectations.
module tb_vram_plane_ctrl;
    localparam int PLANES = 6;
    localparam int AW     = 13;
    localparam int DW     = 8;
    localparam int DEPTH  = 1 << AW;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cpu_ce_n;
    logic                 cpu_wr_n;
    logic [AW-1:0]        cpu_addr;
    logic [DW-1:0]        cpu_din;
    logic [DW-1:0]        cpu_dout;
    logic [7:0]           rd_bank;
    logic [PLANES-1:0]    wr_mask;
    logic                 clr_start;
    logic                 clr_busy;
    logic                 clr_done;
    logic [AW-1:0]        vaddr;
    logic [PLANES*DW-1:0] vdata;

    always #5 clk = ~clk;

    vram_plane_ctrl #(.PLANES(PLANES), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_ce_n  (cpu_ce_n),
        .cpu_wr_n  (cpu_wr_n),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .rd_bank   (rd_bank),
        .wr_mask   (wr_mask),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .vaddr     (vaddr),
        .vdata     (vdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain arrays plus a clear position, updated per edge.
    logic [DW-1:0] m_mem   [PLANES][DEPTH];
    bit            m_known [PLANES][DEPTH];
    logic [DW-1:0] m_dout;
    bit            m_dout_known;
    logic [DW-1:0] m_v       [PLANES];
    bit            m_v_known [PLANES];
    bit            m_busy;
    bit            m_done;
    int            m_clr_pos;
    bit            m_was_busy;

    always @(posedge clk) begin
        if (reset) begin
            m_dout       = '0;
            m_dout_known = 1'b1;
            for (int p = 0; p < PLANES; p++) begin
                m_v[p]       = '0;
                m_v_known[p] = 1'b1;
            end
            m_busy    = 1'b0;
            m_done    = 1'b0;
            m_clr_pos = 0;
        end else begin
            m_was_busy = m_busy;
            for (int p = 0; p < PLANES; p++) begin
                m_v[p]       = m_mem[p][vaddr];
                m_v_known[p] = m_known[p][vaddr];
            end
            if (m_was_busy) begin
                if (!cpu_ce_n && cpu_wr_n) begin
                    m_dout       = '0;
                    m_dout_known = 1'b1;
                end
                for (int p = 0; p < PLANES; p++) begin
                    m_mem[p][m_clr_pos]   = '0;
                    m_known[p][m_clr_pos] = 1'b1;
                end
                m_clr_pos++;
                if (m_clr_pos == DEPTH) begin
                    m_busy    = 1'b0;
                    m_done    = 1'b1;
                    m_clr_pos = 0;
                end
            end else begin
                if (m_done) m_done = 1'b0;
`ifdef VRAM_CLR_EN
                else if (clr_start) begin
                    m_busy    = 1'b1;
                    m_clr_pos = 0;
                end
`endif
                if (!cpu_ce_n && cpu_wr_n) begin
                    if (rd_bank >= 1 && int'(rd_bank) <= PLANES) begin
                        m_dout       = m_mem[int'(rd_bank) - 1][cpu_addr];
                        m_dout_known = m_known[int'(rd_bank) - 1][cpu_addr];
                    end else begin
                        m_dout       = '0;
                        m_dout_known = 1'b1;
                    end
                end else if (!cpu_ce_n && !cpu_wr_n) begin
                    for (int p = 0; p < PLANES; p++) begin
                        if (wr_mask[p]) begin
                            m_mem[p][cpu_addr]   = cpu_din;
                            m_known[p][cpu_addr] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_dout_known) chk("model_cpu_dout", cpu_dout, m_dout);
        for (int p = 0; p < PLANES; p++) begin
            if (m_v_known[p]) chk("model_vdata_plane", vdata[p*DW +: DW], m_v[p]);
        end
        chk("model_clr_busy", clr_busy, m_busy);
        chk("model_clr_done", clr_done, m_done);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [PLANES-1:0] m);
        cpu_ce_n = 1'b0;
        cpu_wr_n = 1'b0;
        cpu_addr = a;
        cpu_din  = d;
        wr_mask  = m;
        tick();
        cpu_ce_n = 1'b1;
        cpu_wr_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, input logic [7:0] bank);
        cpu_ce_n = 1'b0;
        cpu_wr_n = 1'b1;
        cpu_addr = a;
        rd_bank  = bank;
        tick();
        cpu_ce_n = 1'b1;
    endtask

    int busy_cycles;
    int done_pulses;
    logic [AW-1:0] a_v;

    initial begin
        reset     = 1'b1;
        cpu_ce_n  = 1'b1;
        cpu_wr_n  = 1'b1;
        cpu_addr  = '0;
        cpu_din   = '0;
        rd_bank   = 8'd0;
        wr_mask   = '0;
        clr_start = 1'b0;
        vaddr     = '0;
        tick();
        tick();
        chk("rst_cpu_dout", cpu_dout, 0);
        chk("rst_vdata", vdata, 0);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_clr_done", clr_done, 0);
        reset = 1'b0;

        cpu_write(13'h0010, 8'h00, 6'b111111);
        cpu_write(13'h0010, 8'hA5, 6'b000101);
        cpu_read(13'h0010, 8'd1);   chk("rd_bank1", cpu_dout, 8'hA5);
        cpu_read(13'h0010, 8'd3);   chk("rd_bank3", cpu_dout, 8'hA5);
        cpu_read(13'h0010, 8'd2);   chk("rd_bank2", cpu_dout, 8'h00);
        cpu_read(13'h0010, 8'd1);
        cpu_read(13'h0010, 8'd0);   chk("rd_bank0", cpu_dout, 8'h00);
        cpu_read(13'h0010, 8'd3);
        cpu_read(13'h0010, 8'd7);   chk("rd_bank7", cpu_dout, 8'h00);
        cpu_read(13'h0010, 8'd1);
        cpu_read(13'h0010, 8'd255); chk("rd_bank255", cpu_dout, 8'h00);
        cpu_read(13'h0010, 8'd3);
        tick();
        tick();                     chk("dout_hold", cpu_dout, 8'hA5);
        cpu_write(13'h0011, 8'h77, 6'b111111);
        chk("dout_on_write", cpu_dout, 8'hA5);
        cpu_write(13'h0010, 8'h99, 6'b000000);
        cpu_read(13'h0010, 8'd1);   chk("mask0_noop_p1", cpu_dout, 8'hA5);
        cpu_read(13'h0010, 8'd2);   chk("mask0_noop_p2", cpu_dout, 8'h00);

        vaddr = 13'h0010;
        tick();
        chk("vdata_planes", vdata, 48'h0000_00A5_00A5);

        cpu_write(13'h0020, 8'h11, 6'b111111);
        vaddr = 13'h0020;
        cpu_write(13'h0020, 8'h22, 6'b111111);
        chk("collision_old", vdata, {6{8'h11}});
        tick();
        chk("collision_new", vdata, {6{8'h22}});

        cpu_write(13'h1FFF, 8'hC3, 6'b100000);
        cpu_read(13'h1FFF, 8'd6);   chk("top_addr_p6", cpu_dout, 8'hC3);

        for (int i = 0; i < 32; i++) begin
            a_v = 13'(13'h0100 + i * 37);
            cpu_write(a_v, 8'(i * 13) ^ 8'h5A, 6'(i * 11 + 1));
        end
        for (int i = 0; i < 32; i++) begin
            a_v = 13'(13'h0100 + i * 37);
            vaddr = a_v;
            cpu_read(a_v, 8'(i % 9));
        end

`ifdef VRAM_CLR_EN
        for (int a = 0; a < DEPTH; a++) cpu_write(a[AW-1:0], 8'hFF, 6'b111111);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        busy_cycles = 0;
        done_pulses = 0;
        for (int n = 0; n < DEPTH + 100; n++) begin
            if (clr_busy) busy_cycles++;
            if (clr_done) done_pulses++;
            if (n == 102) chk("clr_read_zero", cpu_dout, 8'h00);
            if (n == 100) begin
                cpu_ce_n = 1'b0; cpu_wr_n = 1'b0; cpu_addr = 13'h0005;
                cpu_din = 8'h55; wr_mask = 6'b111111;
            end else if (n == 101) begin
                cpu_wr_n = 1'b1; rd_bank = 8'd1; cpu_addr = 13'h1000;
            end else if (n == 102) begin
                cpu_ce_n = 1'b1; clr_start = 1'b1;
            end else if (n == 103) begin
                clr_start = 1'b0;
            end
            tick();
        end
        chk("clr_busy_cycles", busy_cycles, DEPTH);
        chk("clr_done_pulses", done_pulses, 1);
        for (int a = 0; a < DEPTH; a++) begin
            vaddr = a[AW-1:0];
            tick();
            chk("clr_all_zero", vdata, 0);
        end
        cpu_read(13'h0005, 8'd1);   chk("clr_write_dropped", cpu_dout, 8'h00);

        for (int a = 16'h07F0; a < 16'h0810; a++) cpu_write(a[AW-1:0], 8'hFF, 6'b111111);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (2048) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", clr_busy, 0);
        tick();
        chk("abort_stays_idle", clr_busy, 0);
        cpu_read(13'h07FF, 8'd1);   chk("abort_7ff_cleared", cpu_dout, 8'h00);
        cpu_read(13'h0800, 8'd1);   chk("abort_800_kept", cpu_dout, 8'hFF);
        vaddr = 13'h0800;
        tick();
        chk("abort_800_vdata", vdata, {6{8'hFF}});

        clr_start = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clr_start = 1'b0;
        chk("reset_wins", clr_busy, 0);
        tick();
        chk("reset_wins_idle", clr_busy, 0);
`else
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        chk("noclr_busy", clr_busy, 0);
        chk("noclr_done", clr_done, 0);
        cpu_write(13'h0040, 8'h3C, 6'b111111);
        chk("noclr_busy2", clr_busy, 0);
        cpu_read(13'h0040, 8'd4);   chk("noclr_write_ok", cpu_dout, 8'h3C);
`endif
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
